// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: instruction memory window defaults,
// the canonical NOP, the fetch FSM state encoding and the fetch payload.
package rv32i_pkg;

    localparam logic [31:0] IMEM_BASE_DEF  = 32'h0100_0000;
    localparam int unsigned IMEM_WORDS_DEF = 1024;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // Instruction handed to decode.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } if_payload_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Flags a fetch address that is misaligned or outside the instruction memory.
//   pc_in   : candidate fetch address
//   fault_c : 1 when pc_in cannot be fetched (combinational)
module fetch_addr_check
    import rv32i_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic [31:0] pc_in,
    output logic        fault_c
);

    // End of the window computed one bit wider so a window touching 2^32 cannot wrap.
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BASE) + (33'(IMEM_WORDS) << 2);

    logic misaligned;
    logic below_base;
    logic above_limit;

    assign misaligned  = (pc_in[1:0] != 2'b00);
    assign below_base  = (pc_in < IMEM_BASE);
    assign above_limit = (33'(pc_in) >= IMEM_LIMIT);
    assign fault_c     = misaligned | below_base | above_limit;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one memory request at a time for pc_in, holds the
// returned instruction for decode, and produces the next PC.
//   clk, reset                 : clock, synchronous active-high reset
//   pc_in / next_pc            : PC register value in / next PC out (combinational)
//   redirect, redirect_target  : kill current fetch and steer the PC
//   imem_req/addr/gnt/rvalid/rdata : instruction memory request/response
//   if_valid/if_ready          : decode handshake
//   if_instr/if_pc/if_fault    : held instruction, its PC and fault flag
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    if_payload_t  payload_q;
    if_payload_t  payload_d;
    logic         load_payload;
    logic         addr_fault;

    fetch_addr_check #(
        .IMEM_BASE  (IMEM_BASE),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_addr_check (
        .pc_in   (pc_in),
        .fault_c (addr_fault)
    );

    // State and held payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            payload_q <= '{instr: NOP_INSTR, pc: IMEM_BASE, fault: 1'b0};
        end else begin
            state <= state_nxt;
            if (load_payload) begin
                payload_q <= payload_d;
            end
        end
    end

    // Next state; redirect always wins over the normal progression.
    always_comb begin
        state_nxt = state;
        case (state)
            REQ: begin
                if (addr_fault) begin
                    state_nxt = redirect ? REQ : HOLD;
                end else if (imem_gnt) begin
                    state_nxt = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = redirect ? REQ : HOLD;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            HOLD: begin
                if (redirect || if_ready) begin
                    state_nxt = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    // Outputs and payload capture.
    always_comb begin
        imem_req     = 1'b0;
        imem_addr    = pc_in;
        if_valid     = 1'b0;
        next_pc      = pc_in;
        load_payload = 1'b0;
        payload_d    = '{instr: imem_rdata, pc: pc_in, fault: 1'b0};

        if (reset) begin
            next_pc = IMEM_BASE;
        end else begin
            case (state)
                REQ: begin
                    if (addr_fault) begin
                        // Unfetchable PC: hand decode a faulting NOP instead of a request.
                        payload_d    = '{instr: NOP_INSTR, pc: pc_in, fault: 1'b1};
                        load_payload = !redirect;
                    end else begin
                        imem_req = 1'b1;
                    end
                end
                WAIT:    load_payload = imem_rvalid && !redirect;
                HOLD:    if_valid = !redirect;
                default: ;
            endcase

            if (redirect) begin
                next_pc = redirect_target;
            end else if (state == HOLD && if_ready) begin
                next_pc = pc_in + 32'd4;
            end
        end
    end

    assign if_instr = payload_q.instr;
    assign if_pc    = payload_q.pc;
    assign if_fault = payload_q.fault;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .next_pc         (next_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_fault        (if_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register fed by next_pc.
    always @(posedge clk) pc_in <= next_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every decode handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && if_valid && if_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL hs_unexpected: got pc %08h instr %08h expected no handshake", if_pc, if_instr);
            end else begin
                mon_e = sb.pop_front();
                chk("hs_instr", if_instr, mon_e.instr);
                chk("hs_pc", if_pc, mon_e.pc);
                chk("hs_fault", 32'(if_fault), 32'(mon_e.fault));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;

        // Reset values
        cyc(); cyc();
        smp();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_next_pc", next_pc, BASE);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_if_pc", if_pc, BASE);
        chk("rst_if_fault", 32'(if_fault), 32'd0);
        cyc();

        // Basic fetch, minimum latency
        reset = 1'b0; imem_gnt = 1'b1; if_ready = 1'b1;
        smp();
        chk("t1_req_first", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, BASE);
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        sb.push_back('{instr: 32'h0050_0093, pc: BASE, fault: 1'b0});
        smp();
        chk("t1_wait_req", 32'(imem_req), 32'd0);
        chk("t1_wait_valid", 32'(if_valid), 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        smp();
        chk("t1_valid", 32'(if_valid), 32'd1);
        chk("t1_next_pc", next_pc, 32'h0100_0004);
        cyc();

        // Grant withheld, decode stalled
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("t2_req_held", 32'(imem_req), 32'd1);
            chk("t2_addr", imem_addr, 32'h0100_0004);
            chk("t2_next_pc", next_pc, 32'h0100_0004);
            cyc();
        end
        imem_gnt = 1'b1;
        smp();
        chk("t2_req_gnt", 32'(imem_req), 32'd1);
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00a0_0113;
        sb.push_back('{instr: 32'h00a0_0113, pc: 32'h0100_0004, fault: 1'b0});
        cyc();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t2_hold_valid", 32'(if_valid), 32'd1);
            chk("t2_hold_instr", if_instr, 32'h00a0_0113);
            chk("t2_hold_pc", if_pc, 32'h0100_0004);
            chk("t2_hold_next_pc", next_pc, 32'h0100_0004);
            cyc();
        end
        if_ready = 1'b1;
        smp();
        chk("t2_next_pc_hs", next_pc, 32'h0100_0008);
        cyc();

        // Redirect while waiting: response dropped
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_target = 32'h0100_0040;
        smp();
        chk("t3_redir_next_pc", next_pc, 32'h0100_0040);
        chk("t3_redir_valid", 32'(if_valid), 32'd0);
        cyc();
        redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
        smp();
        chk("t3_drop_req", 32'(imem_req), 32'd0);
        chk("t3_drop_valid", 32'(if_valid), 32'd0);
        chk("t3_drop_next_pc", next_pc, 32'h0100_0040);
        cyc();
        imem_rvalid = 1'b0;
        smp();
        chk("t3_new_req", 32'(imem_req), 32'd1);
        chk("t3_new_addr", imem_addr, 32'h0100_0040);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
        sb.push_back('{instr: 32'h0000_0513, pc: 32'h0100_0040, fault: 1'b0});
        cyc();
        imem_rvalid = 1'b0;
        smp();
        chk("t3_valid", 32'(if_valid), 32'd1);
        cyc();

        // Misaligned and out-of-range PCs
        redirect = 1'b1; redirect_target = 32'h0100_0002;
        smp();
        chk("t4_redir_req", 32'(imem_req), 32'd1);
        chk("t4_redir_next_pc", next_pc, 32'h0100_0002);
        cyc();
        redirect = 1'b0;
        sb.push_back('{instr: NOP, pc: 32'h0100_0002, fault: 1'b1});
        smp();
        chk("t4_misal_req", 32'(imem_req), 32'd0);
        cyc();
        smp();
        chk("t4_misal_valid", 32'(if_valid), 32'd1);
        chk("t4_misal_fault", 32'(if_fault), 32'd1);
        chk("t4_misal_instr", if_instr, NOP);
        chk("t4_misal_next_pc", next_pc, 32'h0100_0006);
        cyc();
        redirect = 1'b1; redirect_target = 32'h0000_0000;
        smp();
        chk("t4_redir_fault_valid", 32'(if_valid), 32'd0);
        cyc();
        redirect = 1'b0;
        sb.push_back('{instr: NOP, pc: 32'h0000_0000, fault: 1'b1});
        smp();
        chk("t4_low_req", 32'(imem_req), 32'd0);
        cyc();
        smp();
        chk("t4_low_valid", 32'(if_valid), 32'd1);
        chk("t4_low_fault", 32'(if_fault), 32'd1);
        chk("t4_low_instr", if_instr, NOP);
        cyc();
        redirect = 1'b1; redirect_target = 32'h0100_1000;
        cyc();
        smp();
        chk("t4_limit_req", 32'(imem_req), 32'd0);
        redirect_target = 32'h0100_0ffc;
        cyc();
        smp();
        chk("t4_last_word_req", 32'(imem_req), 32'd1);
        redirect_target = 32'h0100_0100;
        cyc();
        redirect = 1'b0;

        // Redirect in HOLD beats a ready decode
        if_ready = 1'b0; imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        cyc();
        imem_rvalid = 1'b0; if_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h0100_0200;
        smp();
        chk("t5_valid_killed", 32'(if_valid), 32'd0);
        chk("t5_next_pc", next_pc, 32'h0100_0200);
        cyc();
        redirect = 1'b0; if_ready = 1'b0;
        smp();
        chk("t5_req_state", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, 32'h0100_0200);
        chk("t5_valid", 32'(if_valid), 32'd0);

        // Reset during WAIT
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; reset = 1'b1;
        cyc();
        smp();
        chk("t6_rst_valid", 32'(if_valid), 32'd0);
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        chk("t6_rst_next_pc", next_pc, BASE);
        chk("t6_rst_instr", if_instr, NOP);
        chk("t6_rst_pc", if_pc, BASE);
        reset = 1'b0; if_ready = 1'b1;
        #1;
        chk("t6_resume_req", 32'(imem_req), 32'd1);
        chk("t6_resume_addr", imem_addr, BASE);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
        sb.push_back('{instr: 32'h0010_0073, pc: BASE, fault: 1'b0});
        cyc();
        imem_rvalid = 1'b0;
        smp();
        chk("t6_valid", 32'(if_valid), 32'd1);
        cyc();
        cyc();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
